// File: rtl/minirv_pkg.sv
// minirv_pkg -- shared constants and types for the minirv multi-cycle controller.
//   Opcode / funct3 constants for the supported subset, FSM state enum,
//   write-back and PC select encodings, and the DECODE classifier.
package minirv_pkg;

   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_ALUR   = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRLI = 3'b101;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_SB   = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
   } state_t;

   typedef enum logic [1:0] {
      WB_ALU    = 2'b00,
      WB_MEM_W  = 2'b01,
      WB_MEM_BU = 2'b10,
      WB_PC4    = 2'b11
   } wb_sel_t;

   localparam logic PC_SEL_PLUS4 = 1'b0;
   localparam logic PC_SEL_JALR  = 1'b1;

   typedef enum logic [2:0] {
      DEC_EXEC, DEC_LOAD, DEC_STORE, DEC_SYS, DEC_ILL
   } dec_t;

   function automatic dec_t f_decode(input logic [6:0] op, input logic [2:0] f3);
      dec_t d;
      d = DEC_ILL;
      case (op)
         OP_ALUI:                  d = (f3 == F3_ADDI || f3 == F3_SLLI || f3 == F3_SRLI) ? DEC_EXEC : DEC_ILL;
         OP_ALUR, OP_LUI, OP_JALR: d = DEC_EXEC;
         OP_LOAD:                  d = (f3 == F3_LW || f3 == F3_LBU) ? DEC_LOAD : DEC_ILL;
         OP_STORE:                 d = (f3 == F3_SW || f3 == F3_SB) ? DEC_STORE : DEC_ILL;
         OP_SYSTEM:                d = DEC_SYS;
         default:                  d = DEC_ILL;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/minirv_perf_cnt.sv
// minirv_perf_cnt -- cycle and retired-instruction counters, both wrap at 2^32.
//   clk, rst_n       : clock, async active-low reset
//   i_cyc_en         : count this cycle
//   i_ret            : an instruction retires this cycle (PC update)
//   o_cycle_cnt      : active cycle count
//   o_instret_cnt    : retired instruction count
module minirv_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_cyc_en,
   input  logic        i_ret,
   output logic [31:0] o_cycle_cnt,
   output logic [31:0] o_instret_cnt
);

   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instret_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         if (i_cyc_en) r_cycle_cnt   <= r_cycle_cnt + 32'd1;
         if (i_ret)    r_instret_cnt <= r_instret_cnt + 32'd1;
      end
   end

   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_instret_cnt = r_instret_cnt;

endmodule

// File: rtl/minirv_ctrl.sv
// minirv_ctrl -- multi-cycle control FSM for a minimal RV32 subset
//   (ADDI/SLLI/SRLI, R-type, LUI, JALR, LW/LBU, SW/SB, SYSTEM as halt).
//   Inputs : clk, rst_n, opcode, funct3, addr_lo, mem_ack
//   Outputs: mem_req, mem_is_data, mem_we, mem_wstrb, ir_we, pc_we, rf_wen,
//            pc_sel, wb_sel, halt, illegal, cycle_cnt, instret_cnt
//   Build option: define MINIRV_PERF_CNT_EN to include the performance
//   counters; otherwise cycle_cnt/instret_cnt are tied to 0.
//
//   state  | meaning
//   IDLE   | one cycle after reset, all outputs 0
//   FETCH  | instruction request, IR load on mem_ack
//   DECODE | classify opcode/funct3
//   EXEC   | ALU/LUI/JALR write-back and PC update
//   MEM    | data request, stores retire on mem_ack
//   WB     | load write-back and PC update
//   HALT   | terminal, halt/illegal held until reset
module minirv_ctrl
   import minirv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_is_data,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic        ir_we,
   output logic        pc_we,
   output logic        rf_wen,
   output logic        pc_sel,
   output logic [1:0]  wb_sel,
   output logic        halt,
   output logic        illegal,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
);

   state_t  r_state;
   logic    r_mem_req;
   logic    r_mem_is_data;
   logic    r_mem_we;
   logic    r_is_sb;
   logic    r_is_lbu;
   logic    r_rf_wen;
   logic    r_pc_we;
   logic    r_pc_sel;
   wb_sel_t r_wb_sel;
   logic    r_halt;
   logic    r_illegal;

   dec_t    w_dec;
   logic    w_ack_fetch;
   logic    w_ack_store;

   assign w_dec       = f_decode(opcode, funct3);
   assign w_ack_fetch = (r_state == ST_FETCH) && mem_ack;
   // r_mem_we is only ever set while in MEM for a store
   assign w_ack_store = (r_state == ST_MEM) && r_mem_we && mem_ack;

   // Request controls are registered so they cannot change while a request
   // waits for mem_ack; only the ack-qualified strobes are combinational.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_mem_req     <= 1'b0;
         r_mem_is_data <= 1'b0;
         r_mem_we      <= 1'b0;
         r_is_sb       <= 1'b0;
         r_is_lbu      <= 1'b0;
         r_rf_wen      <= 1'b0;
         r_pc_we       <= 1'b0;
         r_pc_sel      <= PC_SEL_PLUS4;
         r_wb_sel      <= WB_ALU;
         r_halt        <= 1'b0;
         r_illegal     <= 1'b0;
      end else begin
         r_rf_wen <= 1'b0;
         r_pc_we  <= 1'b0;
         r_pc_sel <= PC_SEL_PLUS4;
         r_wb_sel <= WB_ALU;
         case (r_state)
            ST_IDLE: begin
               r_state       <= ST_FETCH;
               r_mem_req     <= 1'b1;
               r_mem_is_data <= 1'b0;
            end
            ST_FETCH: begin
               if (mem_ack) begin
                  r_state   <= ST_DECODE;
                  r_mem_req <= 1'b0;
               end
            end
            ST_DECODE: begin
               r_is_sb  <= (opcode == OP_STORE) && (funct3 == F3_SB);
               r_is_lbu <= (opcode == OP_LOAD) && (funct3 == F3_LBU);
               case (w_dec)
                  DEC_EXEC: begin
                     r_state  <= ST_EXEC;
                     r_rf_wen <= 1'b1;
                     r_pc_we  <= 1'b1;
                     if (opcode == OP_JALR) begin
                        r_wb_sel <= WB_PC4;
                        r_pc_sel <= PC_SEL_JALR;
                     end
                  end
                  DEC_LOAD, DEC_STORE: begin
                     r_state       <= ST_MEM;
                     r_mem_req     <= 1'b1;
                     r_mem_is_data <= 1'b1;
                     r_mem_we      <= (w_dec == DEC_STORE);
                  end
                  DEC_SYS: begin
                     r_state <= ST_HALT;
                     r_halt  <= 1'b1;
                  end
                  default: begin
                     r_state   <= ST_HALT;
                     r_halt    <= 1'b1;
                     r_illegal <= 1'b1;
                  end
               endcase
            end
            ST_EXEC, ST_WB: begin
               r_state       <= ST_FETCH;
               r_mem_req     <= 1'b1;
               r_mem_is_data <= 1'b0;
            end
            ST_MEM: begin
               if (mem_ack) begin
                  r_mem_is_data <= 1'b0;
                  r_mem_we      <= 1'b0;
                  if (r_mem_we) begin
                     // store retired this cycle; next fetch goes out back-to-back
                     r_state <= ST_FETCH;
                  end else begin
                     r_state   <= ST_WB;
                     r_mem_req <= 1'b0;
                     r_rf_wen  <= 1'b1;
                     r_pc_we   <= 1'b1;
                     r_wb_sel  <= r_is_lbu ? WB_MEM_BU : WB_MEM_W;
                  end
               end
            end
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign mem_req     = r_mem_req;
   assign mem_is_data = r_mem_is_data;
   assign mem_we      = r_mem_we;
   // SW ignores addr_lo on purpose: misalignment is handled in the datapath
   assign mem_wstrb   = r_mem_we ? (r_is_sb ? (4'b0001 << addr_lo) : 4'b1111) : 4'b0000;
   assign ir_we       = w_ack_fetch;
   assign pc_we       = r_pc_we | w_ack_store;
   assign rf_wen      = r_rf_wen;
   assign pc_sel      = r_pc_sel;
   assign wb_sel      = r_wb_sel;
   assign halt        = r_halt;
   assign illegal     = r_illegal;

`ifdef MINIRV_PERF_CNT_EN
   logic w_cyc_en;
   assign w_cyc_en = (r_state != ST_IDLE) && (r_state != ST_HALT);

   minirv_perf_cnt u_perf_cnt (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_cyc_en      (w_cyc_en),
      .i_ret         (pc_we),
      .o_cycle_cnt   (cycle_cnt),
      .o_instret_cnt (instret_cnt)
   );
`else
   assign cycle_cnt   = 32'd0;
   assign instret_cnt = 32'd0;
`endif

endmodule

// File: doc/minirv_ctrl.md
MINIRV_CTRL -- requirements
Module: minirv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 7: decoded inst[6:0] of the current IR.
REQ-004 SHALL have port funct3, input, 3: decoded inst[14:12].
REQ-005 SHALL have port addr_lo, input, 2: data address bits [1:0] from the ALU.
REQ-006 SHALL have port mem_ack, input, 1: memory completes the request this cycle.
REQ-007 SHALL have ports mem_req, mem_is_data and mem_we, output, 1 each: request, 0=instruction/1=data, write.
REQ-008 SHALL have port mem_wstrb, output, 4: byte write strobes.
REQ-009 SHALL have ports ir_we, pc_we and rf_wen, output, 1 each: IR load, PC update, register write.
REQ-010 SHALL have port pc_sel, output, 1: 0=pc+4, 1=JALR target with bit0 cleared.
REQ-011 SHALL have port wb_sel, output, 2: 00=ALU, 01=mem word, 10=mem byte zero-ext, 11=pc+4.
REQ-012 SHALL have ports halt and illegal, output, 1 each: sticky stop flags.
REQ-013 SHALL have ports cycle_cnt and instret_cnt, output, 32 each: performance counters.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-015 IDLE SHALL drive all outputs 0 and move to FETCH on the next cycle.
REQ-016 FETCH SHALL drive mem_req=1 and mem_is_data=0; on mem_ack it SHALL pulse ir_we and move to DECODE; otherwise it SHALL hold.
REQ-017 DECODE, for opcode 0010011 with funct3 000/001/101, 0110011, 0110111 or 1100111, SHALL move to EXEC.
REQ-018 DECODE, for 0000011 with funct3 010/100 or 0100011 with funct3 010/000, SHALL move to MEM.
REQ-019 DECODE, for 1110011, SHALL move to HALT with halt=1.
REQ-020 DECODE, for any other opcode/funct3, SHALL move to HALT with halt=1 and illegal=1.
REQ-021 EXEC SHALL pulse rf_wen and pc_we, then return to FETCH.
REQ-022 EXEC wb_sel SHALL be 11 for JALR and 00 otherwise; pc_sel SHALL be 1 only for JALR.
REQ-023 MEM SHALL drive mem_req=1, mem_is_data=1 and mem_we=1 for stores.
REQ-024 MEM mem_wstrb SHALL be 1111 for SW, 0001<<addr_lo for SB and 0000 for loads.
REQ-025 On mem_ack, a store SHALL pulse pc_we and go to FETCH; a load SHALL go to WB.
REQ-026 WB SHALL pulse rf_wen and pc_we with wb_sel 01 (LW) or 10 (LBU), then go to FETCH.
REQ-027 Request controls SHALL stay stable while mem_req=1 and mem_ack=0 (no withdrawal); mem_ack outside FETCH/MEM SHALL be ignored.
REQ-028 Zero-wait latencies SHALL be ALU/LUI/JALR 3 cycles, store 3, load 4.
REQ-029 HALT SHALL be terminal: all strobes 0, halt/illegal held until reset.
REQ-030 SW with addr_lo!=00 SHALL still use strobe 1111; alignment is the datapath's concern.

Reset
REQ-031 rst_n low SHALL force state IDLE, halt=0, illegal=0 and counters 0 immediately (asynchronously), including mid-request; a pending mem_ack SHALL be dropped.
REQ-032 During reset all outputs SHALL be 0.

Configuration
REQ-033 With MINIRV_PERF_CNT_EN defined, cycle_cnt SHALL increment every cycle outside IDLE/HALT and instret_cnt SHALL increment on each pc_we; both SHALL wrap at 2^32.
REQ-034 Without MINIRV_PERF_CNT_EN, both counters SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-035 Package minirv_pkg SHALL hold the opcode/funct3 constants, the state enum, wb_sel encodings and pc_sel encodings.
REQ-036 Counters SHALL live in sub-module minirv_perf_cnt, instantiated only under MINIRV_PERF_CNT_EN.

Verification
REQ-037 Reset release, ADDI (0010011/000) with mem_ack tied 1: ir_we at cycle 2, rf_wen=pc_we=1 with wb_sel=00 at cycle 4.
REQ-038 SB with addr_lo=10 and mem_ack delayed 3 cycles: mem_req, mem_we and wstrb=0100 stable 4 cycles, then pc_we, no rf_wen.
REQ-039 LBU then JALR: WB wb_sel=10; JALR EXEC wb_sel=11 and pc_sel=1; instret_cnt=2.
REQ-040 opcode 1111111: halt=1 and illegal=1, no further mem_req; EBREAK (1110011): halt=1, illegal=0.
REQ-041 rst_n low mid-MEM with mem_req=1: outputs 0 immediately; after release the next request is an instruction fetch.
REQ-042 Build without MINIRV_PERF_CNT_EN: cycle_cnt=instret_cnt=0 after 100 instructions.
